// File: rtl/command_address_mr_tracker.sv
// Registered CA/CS_n forwarder that decodes two-cycle MRW and WRITE commands, keeps a per-rank
// shadow of MR0/MR8/MR50 and emits a write-data descriptor on each completed WRITE.
module command_address_mr_tracker #(
  parameter int unsigned NUM_RANK = 2,
  parameter int unsigned RANK_W   = (NUM_RANK > 1) ? $clog2(NUM_RANK) : 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [13:0]         dfi_address,
  input  logic [NUM_RANK-1:0] dfi_cs_n,
  output logic [NUM_RANK-1:0] CS_n,
  output logic [13:0]         CA,
  output logic                wr_valid,
  output logic [RANK_W-1:0]   wr_rank,
  output logic [5:0]          wr_burst_length,
  output logic [7:0]          wr_pre_pattern,
  output logic [2:0]          wr_pre_cycle,
  output logic [1:0]          wr_post_cycle,
  output logic                wr_crc_en,
  output logic                cmd_err
);

  localparam logic [4:0] CmdMrw   = 5'b00101;
  localparam logic [4:0] CmdWrite = 5'b01101;
  localparam logic [7:0] Mr0      = 8'd0;
  localparam logic [7:0] Mr8      = 8'd8;
  localparam logic [7:0] Mr50     = 8'd50;

  typedef enum logic [1:0] {StIdle, StMrw2nd, StWr2nd} state_e;

  state_e              state_q, state_d;
  logic [NUM_RANK-1:0] mask_q, mask_d;
  logic [7:0]          mr_addr_q, mr_addr_d;
  logic [RANK_W-1:0]   idx_q, idx_d;

  // Per-rank mode-register shadow
  logic [5:0] bl_q   [NUM_RANK];
  logic [5:0] bl_d   [NUM_RANK];
  logic [7:0] pat_q  [NUM_RANK];
  logic [7:0] pat_d  [NUM_RANK];
  logic [2:0] pcyc_q [NUM_RANK];
  logic [2:0] pcyc_d [NUM_RANK];
  logic [1:0] post_q [NUM_RANK];
  logic [1:0] post_d [NUM_RANK];
  logic       crc_q  [NUM_RANK];
  logic       crc_d  [NUM_RANK];

  logic [NUM_RANK-1:0] cs_n_q;
  logic [13:0]         ca_q;
  logic                wr_valid_q, wr_valid_d;
  logic [RANK_W-1:0]   wr_rank_q, wr_rank_d;
  logic [5:0]          wr_bl_q, wr_bl_d;
  logic [7:0]          wr_pat_q, wr_pat_d;
  logic [2:0]          wr_pcyc_q, wr_pcyc_d;
  logic [1:0]          wr_post_q, wr_post_d;
  logic                wr_crc_q, wr_crc_d;
  logic                cmd_err_q, cmd_err_d;

  logic [NUM_RANK-1:0] sel;
  logic                sel_any;
  logic                sel_onehot;
  logic [RANK_W-1:0]   sel_idx;
  logic [4:0]          cmd;
  logic [7:0]          op;

  always_comb begin
    sel        = ~dfi_cs_n;
    sel_any    = (sel != '0);
    sel_onehot = sel_any && ((sel & (sel - NUM_RANK'(1))) == '0);
    sel_idx    = '0;
    for (int i = 0; i < int'(NUM_RANK); i++) begin
      if (sel[i]) sel_idx = RANK_W'(i);
    end
    cmd = dfi_address[4:0];
    op  = dfi_address[7:0];
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    mr_addr_d  = mr_addr_q;
    idx_d      = idx_q;
    bl_d       = bl_q;
    pat_d      = pat_q;
    pcyc_d     = pcyc_q;
    post_d     = post_q;
    crc_d      = crc_q;
    wr_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    wr_rank_d  = wr_rank_q;
    wr_bl_d    = wr_bl_q;
    wr_pat_d   = wr_pat_q;
    wr_pcyc_d  = wr_pcyc_q;
    wr_post_d  = wr_post_q;
    wr_crc_d   = wr_crc_q;

    case (state_q)
      StIdle: begin
        if (sel_any && cmd == CmdMrw) begin
          mask_d    = sel;
          mr_addr_d = dfi_address[12:5];
          state_d   = StMrw2nd;
        end else if (sel_any && cmd == CmdWrite) begin
          if (sel_onehot) begin
            idx_d   = sel_idx;
            state_d = StWr2nd;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      StMrw2nd: begin
        state_d = StIdle;
        if (sel_any) begin
          cmd_err_d = 1'b1;
        end else if (!dfi_address[10]) begin
          for (int i = 0; i < int'(NUM_RANK); i++) begin
            if (mask_q[i]) begin
              case (mr_addr_q)
                Mr0: bl_d[i] = op[1] ? 6'd32 : (op[0] ? 6'd8 : 6'd16);
                Mr8: begin
                  // op[4:3]=00 is reserved and leaves the preamble untouched
                  case (op[4:3])
                    2'b01: begin pat_d[i] = 8'h02; pcyc_d[i] = 3'd2; end
                    2'b10: begin pat_d[i] = 8'h02; pcyc_d[i] = 3'd3; end
                    2'b11: begin pat_d[i] = 8'h0A; pcyc_d[i] = 3'd4; end
                    default: ;
                  endcase
                  post_d[i] = op[7] ? 2'b10 : 2'b01;
                end
                Mr50:    crc_d[i] = |op[2:1];
                default: ;
              endcase
            end
          end
        end
      end
      StWr2nd: begin
        state_d = StIdle;
        if (sel_any) begin
          cmd_err_d = 1'b1;
        end else begin
          wr_valid_d = 1'b1;
          wr_rank_d  = idx_q;
          wr_bl_d    = dfi_address[5] ? bl_q[idx_q] : 6'd8;
          wr_pat_d   = pat_q[idx_q];
          wr_pcyc_d  = pcyc_q[idx_q];
          wr_post_d  = post_q[idx_q];
          wr_crc_d   = crc_q[idx_q];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      mr_addr_q  <= '0;
      idx_q      <= '0;
      for (int i = 0; i < int'(NUM_RANK); i++) begin
        bl_q[i]   <= 6'd16;
        pat_q[i]  <= 8'h02;
        pcyc_q[i] <= 3'd2;
        post_q[i] <= 2'b01;
        crc_q[i]  <= 1'b0;
      end
      cs_n_q     <= '1;
      ca_q       <= '0;
      wr_valid_q <= 1'b0;
      wr_rank_q  <= '0;
      wr_bl_q    <= '0;
      wr_pat_q   <= '0;
      wr_pcyc_q  <= '0;
      wr_post_q  <= '0;
      wr_crc_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else if (i_enable) begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      mr_addr_q  <= mr_addr_d;
      idx_q      <= idx_d;
      bl_q       <= bl_d;
      pat_q      <= pat_d;
      pcyc_q     <= pcyc_d;
      post_q     <= post_d;
      crc_q      <= crc_d;
      cs_n_q     <= dfi_cs_n;
      ca_q       <= dfi_address;
      wr_valid_q <= wr_valid_d;
      wr_rank_q  <= wr_rank_d;
      wr_bl_q    <= wr_bl_d;
      wr_pat_q   <= wr_pat_d;
      wr_pcyc_q  <= wr_pcyc_d;
      wr_post_q  <= wr_post_d;
      wr_crc_q   <= wr_crc_d;
      cmd_err_q  <= cmd_err_d;
    end else begin
      wr_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end
  end

  // Strobes are forced low for as long as the block is frozen
  assign wr_valid        = wr_valid_q & i_enable;
  assign cmd_err         = cmd_err_q & i_enable;
  assign CS_n            = cs_n_q;
  assign CA              = ca_q;
  assign wr_rank         = wr_rank_q;
  assign wr_burst_length = wr_bl_q;
  assign wr_pre_pattern  = wr_pat_q;
  assign wr_pre_cycle    = wr_pcyc_q;
  assign wr_post_cycle   = wr_post_q;
  assign wr_crc_en       = wr_crc_q;

endmodule

// File: tb/tb_command_address_mr_tracker.sv
// Randomized bench for command_address_mr_tracker against a transaction-level reference model,
// plus directed command sequences with hand-derived expectations.
module tb_command_address_mr_tracker;

  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [13:0]   addr;
  logic [NR-1:0] csn;
  logic [NR-1:0] CS_n;
  logic [13:0]   CA;
  logic          wr_valid;
  logic [0:0]    wr_rank;
  logic [5:0]    wr_burst_length;
  logic [7:0]    wr_pre_pattern;
  logic [2:0]    wr_pre_cycle;
  logic [1:0]    wr_post_cycle;
  logic          wr_crc_en;
  logic          cmd_err;

  command_address_mr_tracker #(.NUM_RANK(NR)) dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_enable        (en),
    .dfi_address     (addr),
    .dfi_cs_n        (csn),
    .CS_n            (CS_n),
    .CA              (CA),
    .wr_valid        (wr_valid),
    .wr_rank         (wr_rank),
    .wr_burst_length (wr_burst_length),
    .wr_pre_pattern  (wr_pre_pattern),
    .wr_pre_cycle    (wr_pre_cycle),
    .wr_post_cycle   (wr_post_cycle),
    .wr_crc_en       (wr_crc_en),
    .cmd_err         (cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: rank shadows plus the command awaiting its second cycle
  int m_bl[NR], m_pat[NR], m_cyc[NR], m_post[NR], m_crc[NR];
  int pend;           // 0 none, 1 MRW, 2 WRITE
  int p_mr, p_rank;
  bit [NR-1:0] p_mask;
  int e_ca, e_csn, e_v, e_err, e_rank, e_bl, e_pat, e_cyc, e_post, e_crc;

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) begin
      m_bl[r] = 16; m_pat[r] = 2; m_cyc[r] = 2; m_post[r] = 1; m_crc[r] = 0;
    end
    pend = 0;
    e_ca = 0; e_csn = (1 << NR) - 1; e_v = 0; e_err = 0;
    e_rank = 0; e_bl = 0; e_pat = 0; e_cyc = 0; e_post = 0; e_crc = 0;
  endfunction

  function automatic void apply_mr(int r, int mr, int o);
    if (mr == 0) begin
      if (o % 4 >= 2) m_bl[r] = 32;
      else if (o % 2 == 1) m_bl[r] = 8;
      else m_bl[r] = 16;
    end else if (mr == 8) begin
      case ((o / 8) % 4)
        1: begin m_pat[r] = 2;  m_cyc[r] = 2; end
        2: begin m_pat[r] = 2;  m_cyc[r] = 3; end
        3: begin m_pat[r] = 10; m_cyc[r] = 4; end
        default: ;
      endcase
      m_post[r] = (o >= 128) ? 2 : 1;
    end else if (mr == 50) begin
      m_crc[r] = ((o / 2) % 4 != 0) ? 1 : 0;
    end
  endfunction

  function automatic void model_step(bit r_n, bit e, bit [13:0] a, bit [NR-1:0] cs);
    bit [NR-1:0] sel;
    if (!r_n) begin
      model_reset();
      return;
    end
    e_v = 0;
    e_err = 0;
    if (!e) return;
    e_ca = a;
    e_csn = cs;
    sel = ~cs;
    if (pend == 0) begin
      if (sel != 0 && a[4:0] == 5'd5) begin
        pend = 1; p_mask = sel; p_mr = a[12:5];
      end else if (sel != 0 && a[4:0] == 5'd13) begin
        if ($countones(sel) == 1) begin
          pend = 2;
          for (int r = 0; r < NR; r++) if (sel[r]) p_rank = r;
        end else e_err = 1;
      end
    end else if (sel != 0) begin
      e_err = 1; pend = 0;
    end else if (pend == 1) begin
      pend = 0;
      if (!a[10]) for (int r = 0; r < NR; r++) if (p_mask[r]) apply_mr(r, p_mr, a[7:0]);
    end else begin
      pend = 0;
      e_v = 1; e_rank = p_rank;
      e_bl = a[5] ? m_bl[p_rank] : 8;
      e_pat = m_pat[p_rank]; e_cyc = m_cyc[p_rank];
      e_post = m_post[p_rank]; e_crc = m_crc[p_rank];
    end
  endfunction

  task automatic cyc(input bit r_n, input bit e, input bit [13:0] a, input bit [NR-1:0] cs);
    @(negedge clk);
    rst_n = r_n; en = e; addr = a; csn = cs;
    @(posedge clk);
    model_step(r_n, e, a, cs);
    #1;
    check_eq("ca", 32'(CA), 32'(e_ca));
    check_eq("cs_n", 32'(CS_n), 32'(e_csn));
    check_eq("wr_valid", 32'(wr_valid), 32'(e_v));
    check_eq("cmd_err", 32'(cmd_err), 32'(e_err));
    check_eq("wr_rank", 32'(wr_rank), 32'(e_rank));
    check_eq("wr_bl", 32'(wr_burst_length), 32'(e_bl));
    check_eq("wr_pre_pattern", 32'(wr_pre_pattern), 32'(e_pat));
    check_eq("wr_pre_cycle", 32'(wr_pre_cycle), 32'(e_cyc));
    check_eq("wr_post_cycle", 32'(wr_post_cycle), 32'(e_post));
    check_eq("wr_crc_en", 32'(wr_crc_en), 32'(e_crc));
  endtask

  task automatic do_write(input int r, input bit a5);
    bit [NR-1:0] cs;
    cs = ~(NR'(1) << r);
    cyc(1'b1, 1'b1, 14'h000D, cs);
    cyc(1'b1, 1'b1, a5 ? 14'h0020 : 14'h0000, '1);
  endtask

  task automatic do_mrw(input bit [NR-1:0] cs, input bit [7:0] mr, input bit [7:0] o,
                        input bit cancel);
    cyc(1'b1, 1'b1, {1'b0, mr, 5'b00101}, cs);
    cyc(1'b1, 1'b1, {3'b000, cancel, 2'b00, o}, '1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; addr = '0; csn = '1;
    model_reset();
    cyc(1'b0, 1'b1, 14'h0000, 2'b11);
    check_eq("rst_cs_n", 32'(CS_n), 32'h3);

    // Default descriptor for rank 0
    cyc(1'b1, 1'b1, 14'h000D, 2'b10);
    check_eq("echo_ca", 32'(CA), 32'h000D);
    check_eq("echo_cs_n", 32'(CS_n), 32'h2);
    cyc(1'b1, 1'b1, 14'h0020, 2'b11);
    check_eq("w0_valid", 32'(wr_valid), 32'h1);
    check_eq("w0_bl", 32'(wr_burst_length), 32'd16);
    check_eq("w0_pat", 32'(wr_pre_pattern), 32'h02);
    check_eq("w0_post", 32'(wr_post_cycle), 32'h1);

    // MR8 op 0x98 on rank 1 only
    do_mrw(2'b01, 8'd8, 8'h98, 1'b0);
    do_write(1, 1'b1);
    check_eq("mr8_pat", 32'(wr_pre_pattern), 32'h0A);
    check_eq("mr8_cyc", 32'(wr_pre_cycle), 32'd4);
    check_eq("mr8_post", 32'(wr_post_cycle), 32'h2);
    do_write(0, 1'b1);
    check_eq("r0_pat_default", 32'(wr_pre_pattern), 32'h02);

    // Multicast MR0 BL32 and MR50 CRC
    do_mrw(2'b00, 8'd0, 8'h02, 1'b0);
    do_mrw(2'b00, 8'd50, 8'h02, 1'b0);
    do_write(1, 1'b1);
    check_eq("mc_bl_r1", 32'(wr_burst_length), 32'd32);
    check_eq("mc_crc_r1", 32'(wr_crc_en), 32'h1);
    do_write(0, 1'b0);
    check_eq("bl8_otf", 32'(wr_burst_length), 32'd8);

    // Cancelled MRW, then reserved MR8 preamble code
    do_mrw(2'b10, 8'd0, 8'h01, 1'b1);
    do_mrw(2'b10, 8'd8, 8'h80, 1'b0);
    do_write(0, 1'b1);
    check_eq("cancel_bl", 32'(wr_burst_length), 32'd32);
    check_eq("rsvd_pat", 32'(wr_pre_cycle), 32'd2);
    check_eq("rsvd_post", 32'(wr_post_cycle), 32'h2);

    // Illegal sequences
    cyc(1'b1, 1'b1, 14'h000D, 2'b00);
    check_eq("err_multi", 32'(cmd_err), 32'h1);
    cyc(1'b1, 1'b1, 14'h0000, 2'b11);
    check_eq("err_pulse", 32'(cmd_err), 32'h0);
    cyc(1'b1, 1'b1, 14'h000D, 2'b10);
    cyc(1'b1, 1'b1, 14'h0020, 2'b01);
    check_eq("err_2nd", 32'(cmd_err), 32'h1);
    check_eq("err_2nd_nv", 32'(wr_valid), 32'h0);

    // Freeze between the two WRITE cycles
    cyc(1'b1, 1'b1, 14'h000D, 2'b01);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 14'(i * 7 + 1), 2'b00);
      check_eq("frz_ca", 32'(CA), 32'h000D);
    end
    cyc(1'b1, 1'b1, 14'h0020, 2'b11);
    check_eq("frz_valid", 32'(wr_valid), 32'h1);
    check_eq("frz_rank", 32'(wr_rank), 32'h1);

    // Reset while waiting for the WRITE second cycle
    cyc(1'b1, 1'b1, 14'h000D, 2'b01);
    cyc(1'b0, 1'b1, 14'h0020, 2'b11);
    check_eq("rst_wr_nv", 32'(wr_valid), 32'h0);
    do_write(1, 1'b1);
    check_eq("rst_bl", 32'(wr_burst_length), 32'd16);
    check_eq("rst_pat", 32'(wr_pre_pattern), 32'h02);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit [13:0] a;
      bit [NR-1:0] cs;
      bit [7:0] mr;
      int k;
      a = 14'($urandom);
      k = $urandom_range(0, 3);
      mr = (k == 0) ? 8'd0 : (k == 1) ? 8'd8 : (k == 2) ? 8'd50 : 8'($urandom);
      k = $urandom_range(0, 3);
      if (k == 0) a[4:0] = 5'b00101;
      else if (k == 1) a[4:0] = 5'b01101;
      a[12:5] = ($urandom_range(0, 1) == 1) ? mr : a[12:5];
      cs = ($urandom_range(0, 1) == 1) ? 2'b11 : NR'($urandom_range(0, 3));
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), a, cs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/command_address_mr_tracker.md
Name: command_address_mr_tracker

Overview:
- Successor to the single-rank command/address forwarder; sits between the frequency-ratio block and the DRAM CA interface.
- Forwards dfi_address/dfi_cs_n to CA/CS_n with one cycle of registration.
- Decodes 2-cycle MRW and WRITE commands and keeps a per-rank shadow of MR0, MR8 and MR50.
- On each WRITE it emits a one-cycle descriptor to the write-data block holding the addressed rank's burst length, preamble, postamble and CRC configuration.

Parameters:
- NUM_RANK, 2, number of ranks (chip selects); legal range 1..8.
- RANK_W, (NUM_RANK>1 ? $clog2(NUM_RANK) : 1), width of rank index; derived, not overridden.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous active-low reset.
- i_enable  in  1  advance enable; 0 freezes the block.
- dfi_address  in  14  command/address bus.
- dfi_cs_n  in  NUM_RANK  chip selects, active low.
- CS_n  out  NUM_RANK  registered chip selects.
- CA  out  14  registered command bus.
- wr_valid  out  1  one-cycle WRITE descriptor strobe.
- wr_rank  out  RANK_W  index of the rank written.
- wr_burst_length  out  6  8, 16 or 32.
- wr_pre_pattern  out  8  preamble pattern.
- wr_pre_cycle  out  3  preamble length in cycles.
- wr_post_cycle  out  2  01 = 0.5 cycle, 10 = 1.5 cycle.
- wr_crc_en  out  1  write CRC required.
- cmd_err  out  1  one-cycle illegal-sequence strobe.

Behaviour:
- Reset (sampled at posedge, i_reset=0):
  - CA=0, CS_n=all 1, state=IDLE, wr_valid=0, cmd_err=0.
  - All wr_* outputs = 0.
  - Every rank shadow loads BL=16, pre_pattern=8'b00000010, pre_cycle=2, post_cycle=2'b01, crc_en=0.
- i_enable=0: state, shadows, CA, CS_n and wr_* hold; wr_valid and cmd_err are driven 0.
- i_enable=1:
  - CA<=dfi_address and CS_n<=dfi_cs_n every cycle (latency 1), independent of decode.
- FSM states: IDLE, MRW_2ND, WR_2ND. Sel = ~dfi_cs_n.
  - IDLE, Sel!=0, dfi_address[4:0]=00101 (MRW): latch rank_mask=Sel and mr_addr=dfi_address[12:5]; go to MRW_2ND. Multicast is allowed: all selected ranks update.
  - IDLE, Sel!=0, dfi_address[4:0]=01101 (WRITE):
    - Sel one-hot: latch rank index; go to WR_2ND.
    - Sel not one-hot: cmd_err=1 next cycle; stay IDLE.
  - IDLE, any other command: stay IDLE; no decode.
  - MRW_2ND or WR_2ND with Sel!=0: cmd_err=1 next cycle; go to IDLE without decoding this cycle as a new command.
  - MRW_2ND, Sel=0, dfi_address[10]=1: cancelled; go to IDLE; no update.
  - MRW_2ND, Sel=0, dfi_address[10]=0: op=dfi_address[7:0]; update each masked rank at this clock edge; go to IDLE. Decode:
    - MR0, op[1:0]: 00 → BL16; 01 → BL8; 1x → BL32.
    - MR8, op[4:3]: 00 → reserved, preamble unchanged; 01 → pattern 00000010, 2 cycles; 10 → pattern 00000010, 3 cycles; 11 → pattern 00001010, 4 cycles.
    - MR8, op[7]: 0 → post 01; 1 → post 10.
    - MR50: crc_en = (op[2:1]!=0).
    - Any other MR address: ignored.
  - WR_2ND, Sel=0: at the next edge:
    - wr_valid=1 and wr_rank=latched index.
    - wr_burst_length = rank's MR0 BL if dfi_address[5]=1, else 8.
    - Remaining wr_* = that rank's shadow as it stands before this edge.
    - Go to IDLE.
- Timing:
  - WRITE first cycle at input cycle T gives wr_valid at T+2, coincident with CA carrying the second WRITE cycle.
  - An MRW whose second cycle is at T is visible to a WRITE whose first cycle is at T+1.
- wr_* hold their last values when wr_valid=0.
- Back-to-back commands: IDLE can accept a new first cycle on the cycle right after a second cycle.

Test Plan:
- Reset, then WRITE to rank0 (cs_n=10, CA=0x000D; then cs_n=11, CA[5]=1) → wr_valid at T+2, wr_rank=0, BL=16, pre_pattern=0x02, pre_cycle=2, post=01, crc_en=0; CA/CS_n echo inputs with 1-cycle delay.
- MRW MR8 (CA=0x0105, cs_n=01) then op 0x98 → later WRITE to rank1 gives pre_pattern=0x0A, pre_cycle=4, post=10; WRITE to rank0 still gives defaults.
- Multicast MRW MR0 (cs_n=00, CA=0x0005) with op 0x02, then MR50 op 0x02 → WRITEs to both ranks give BL=32 and crc_en=1; a WRITE with CA[5]=0 gives BL=8.
- MRW second cycle with CA[10]=1 → no shadow change; MR8 op[4:3]=00 → preamble unchanged, postamble still updates.
- WRITE with cs_n=00, and a first cycle followed by cs_n low in the second cycle → cmd_err pulses 1 cycle, no wr_valid, FSM returns to IDLE.
- i_enable=0 held 3 cycles mid-WRITE (between the two cycles) → outputs frozen, wr_valid=0; after re-enable the second cycle completes normally. Reset asserted in WR_2ND → no wr_valid, shadows return to defaults.
